// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register_file_sb slice.
//   DEF_WIDTH / DEF_DEPTH : default register width and register count
//   AW                    : address width for the default depth
//   ZERO_IDX              : index of the hardwired zero register
//   reg_addr_t/reg_data_t : address and data types at default sizes
//   is_zero_idx()         : true when an index names the hardwired zero register
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 24;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned AW        = $clog2(DEF_DEPTH);
  localparam int unsigned ZERO_IDX  = 0;

  typedef logic [AW-1:0]        reg_addr_t;
  typedef logic [DEF_WIDTH-1:0] reg_data_t;

  function automatic logic is_zero_idx(input int unsigned idx, input bit zero_en);
    return zero_en && (idx == ZERO_IDX);
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for multi-cycle producers.
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset (clears all busy bits and conflict)
//   i_set_en     reserve request (marks i_set_reg busy)
//   i_set_reg    register being reserved
//   i_clr_en     writeback (clears busy for i_clr_reg)
//   i_clr_reg    register being written back
//   i_addr_a/b   lookup addresses
//   o_busy_a/b   busy bit at i_addr_a / i_addr_b (combinational)
//   o_conflict   one-cycle pulse: reserve hit a register that was still busy
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  bit          ZERO_REG = 1'b1,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_reg,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_reg,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [ADDR_W-1:0] i_addr_b,
  output logic              o_busy_a,
  output logic              o_busy_b,
  output logic              o_conflict
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             r_conflict;
  logic             w_conflict_nxt;
  logic             w_set_is_zero;

  assign w_set_is_zero = is_zero_idx(int'(i_set_reg), ZERO_REG);

  // Clear is applied first so a same-register reserve overrides it:
  // the newly issued producer is still in flight.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) begin
      w_busy_nxt[i_clr_reg] = 1'b0;
    end
    if (i_set_en) begin
      w_busy_nxt[i_set_reg] = 1'b1;
    end
    if (ZERO_REG) begin
      w_busy_nxt[ADDR_W'(ZERO_IDX)] = 1'b0;
    end
  end

  // A reserve collides only if the old producer is not retiring this cycle.
  always_comb begin
    w_conflict_nxt = i_set_en && !w_set_is_zero && r_busy[i_set_reg]
                     && !(i_clr_en && (i_clr_reg == i_set_reg));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_conflict <= w_conflict_nxt;
    end
  end

  assign o_busy_a   = r_busy[i_addr_a];
  assign o_busy_b   = r_busy[i_addr_b];
  assign o_conflict = r_conflict;

endmodule : regfile_scoreboard

// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with scoreboard and MULREG.
//   Clock, ResetN          rising-edge clock, synchronous active-low reset
//   RS/RT -> ReadRS/ReadRT two combinational read ports
//   RD, WriteData, RegWrite writeback port (also clears busy[RD])
//   Reserve, ReserveReg    marks a register busy for a multi-cycle producer
//   RSBusy/RTBusy          busy state of RS/RT (combinational)
//   Conflict               registered pulse: reserve of an already-busy register
//   MulWrite, MulData      load of the 2*WIDTH product register
//   MulHi/MulLo            upper/lower halves of MULREG
// Optional build macro REGFILE_BYPASS_EN: same-cycle write-through forwarding
// to both read ports and the matching busy outputs.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEF_WIDTH,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  bit          ZERO_REG = 1'b1,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic [ADDR_W-1:0]  RS,
  input  logic [ADDR_W-1:0]  RT,
  output logic [WIDTH-1:0]   ReadRS,
  output logic [WIDTH-1:0]   ReadRT,
  input  logic [ADDR_W-1:0]  RD,
  input  logic [WIDTH-1:0]   WriteData,
  input  logic               RegWrite,
  input  logic               Reserve,
  input  logic [ADDR_W-1:0]  ReserveReg,
  output logic               RSBusy,
  output logic               RTBusy,
  output logic               Conflict,
  input  logic               MulWrite,
  input  logic [2*WIDTH-1:0] MulData,
  output logic [WIDTH-1:0]   MulHi,
  output logic [WIDTH-1:0]   MulLo
);

  logic [WIDTH-1:0]   r_regs [DEPTH];
  logic [2*WIDTH-1:0] r_mul;

  logic w_wr_en;
  logic w_rs_zero;
  logic w_rt_zero;
  logic w_busy_rs;
  logic w_busy_rt;

  assign w_wr_en   = RegWrite && !is_zero_idx(int'(RD), ZERO_REG);
  assign w_rs_zero = is_zero_idx(int'(RS), ZERO_REG);
  assign w_rt_zero = is_zero_idx(int'(RT), ZERO_REG);

  // ---------------------------------------------------------------- storage
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_mul <= '0;
    end else begin
      if (w_wr_en) begin
        r_regs[RD] <= WriteData;
      end
      if (MulWrite) begin
        r_mul <= MulData;
      end
    end
  end

  // ------------------------------------------------------------- scoreboard
  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk      (Clock),
    .i_rst_n    (ResetN),
    .i_set_en   (Reserve),
    .i_set_reg  (ReserveReg),
    .i_clr_en   (RegWrite),
    .i_clr_reg  (RD),
    .i_addr_a   (RS),
    .i_addr_b   (RT),
    .o_busy_a   (w_busy_rs),
    .o_busy_b   (w_busy_rt),
    .o_conflict (Conflict)
  );

  // ------------------------------------------------------------------ reads
`ifdef REGFILE_BYPASS_EN
  logic w_fwd_rs;
  logic w_fwd_rt;

  // w_wr_en already excludes the zero register, so no forwarding from it.
  assign w_fwd_rs = w_wr_en && (RS == RD);
  assign w_fwd_rt = w_wr_en && (RT == RD);

  always_comb begin
    ReadRS = r_regs[RS];
    ReadRT = r_regs[RT];
    RSBusy = w_busy_rs;
    RTBusy = w_busy_rt;
    if (w_fwd_rs) begin
      ReadRS = WriteData;
      // The retiring write makes the register ready now, unless a new
      // producer is being reserved onto it in the same cycle.
      if (!(Reserve && (ReserveReg == RS))) begin
        RSBusy = 1'b0;
      end
    end
    if (w_fwd_rt) begin
      ReadRT = WriteData;
      if (!(Reserve && (ReserveReg == RT))) begin
        RTBusy = 1'b0;
      end
    end
    if (w_rs_zero) begin
      ReadRS = '0;
      RSBusy = 1'b0;
    end
    if (w_rt_zero) begin
      ReadRT = '0;
      RTBusy = 1'b0;
    end
  end
`else
  always_comb begin
    ReadRS = r_regs[RS];
    ReadRT = r_regs[RT];
    RSBusy = w_busy_rs;
    RTBusy = w_busy_rt;
    if (w_rs_zero) begin
      ReadRS = '0;
      RSBusy = 1'b0;
    end
    if (w_rt_zero) begin
      ReadRT = '0;
      RTBusy = 1'b0;
    end
  end
`endif

  // ----------------------------------------------------------------- MULREG
  assign MulHi = r_mul[2*WIDTH-1:WIDTH];
  assign MulLo = r_mul[WIDTH-1:0];

endmodule : register_file_sb

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb (default 24x16, ZERO_REG=1).
// Behavioural model: arrays for registers and busy flags, updated from the
// architectural rules once per clock edge.
module tb_register_file_sb;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic [3:0]  RS, RT, RD, ReserveReg;
  logic [23:0] ReadRS, ReadRT, WriteData, MulHi, MulLo;
  logic        RegWrite, Reserve, MulWrite;
  logic        RSBusy, RTBusy, Conflict;
  logic [47:0] MulData;

  int n_cmp  = 0;
  int n_fail = 0;

  // model state
  logic [23:0] m_regs [16];
  bit          m_busy [16];
  bit          m_conf;
  logic [47:0] m_mul;
  bit          m_valid = 1'b0;

  always #5 Clock = ~Clock;

  register_file_sb #(
    .WIDTH    (24),
    .DEPTH    (16),
    .ZERO_REG (1'b1)
  ) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .RS         (RS),
    .RT         (RT),
    .ReadRS     (ReadRS),
    .ReadRT     (ReadRT),
    .RD         (RD),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite),
    .Reserve    (Reserve),
    .ReserveReg (ReserveReg),
    .RSBusy     (RSBusy),
    .RTBusy     (RTBusy),
    .Conflict   (Conflict),
    .MulWrite   (MulWrite),
    .MulData    (MulData),
    .MulHi      (MulHi),
    .MulLo      (MulLo)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic [3:0] rs, input logic [3:0] rt,
                       input logic we, input logic [3:0] rd, input logic [23:0] wd,
                       input logic res, input logic [3:0] rr,
                       input logic mw, input logic [47:0] md);
    ResetN = rst_n; RS = rs; RT = rt; RegWrite = we; RD = rd; WriteData = wd;
    Reserve = res; ReserveReg = rr; MulWrite = mw; MulData = md;
  endtask

  function automatic bit fwd(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
    return RegWrite && (RD == a) && (a != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [23:0] exp_data(input logic [3:0] a);
    if (a == 0)  return 24'h0;
    if (fwd(a))  return WriteData;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    if (a == 0) return 1'b0;
    if (fwd(a) && !(Reserve && ReserveReg == a)) return 1'b0;
    return m_busy[a];
  endfunction

  // Compare every output against the model with the current inputs applied.
  task automatic check_all(input string tag);
    if (m_valid) begin
      chk({tag, ".ReadRS"}, 48'(ReadRS), 48'(exp_data(RS)));
      chk({tag, ".ReadRT"}, 48'(ReadRT), 48'(exp_data(RT)));
      chk({tag, ".RSBusy"}, 48'(RSBusy), 48'(exp_busy(RS)));
      chk({tag, ".RTBusy"}, 48'(RTBusy), 48'(exp_busy(RT)));
      chk({tag, ".Conflict"}, 48'(Conflict), 48'(m_conf));
      chk({tag, ".MulHi"}, 48'(MulHi), 48'(m_mul[47:24]));
      chk({tag, ".MulLo"}, 48'(MulLo), 48'(m_mul[23:0]));
    end
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic commit();
    bit conf_n;
    @(posedge Clock);
    if (!ResetN) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_mul   = '0;
      m_conf  = 1'b0;
      m_valid = 1'b1;
    end else begin
      conf_n = Reserve && (ReserveReg != 0) && m_busy[ReserveReg]
               && !(RegWrite && RD == ReserveReg);
      if (RegWrite && RD != 0) m_regs[RD] = WriteData;
      if (RegWrite) m_busy[RD] = 1'b0;
      if (Reserve && ReserveReg != 0) m_busy[ReserveReg] = 1'b1;
      m_busy[0] = 1'b0;
      if (MulWrite) m_mul = MulData;
      m_conf = conf_n;
    end
    #1;
  endtask

  task automatic cyc(input string tag);
    #4;
    check_all(tag);
    commit();
  endtask

  initial begin
    // 1. reset held two cycles, then read every address
    drive(0, 0, 0, 1, 4'd5, 24'hFFFFFF, 1, 4'd5, 1, 48'hFFFF_FFFF_FFFF);
    cyc("rst0");
    cyc("rst1");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      RS = 4'(i); RT = 4'(15 - i);
      #1;
      chk("t1.ReadRS", 48'(ReadRS), 48'h0);
      chk("t1.ReadRT", 48'(ReadRT), 48'h0);
      chk("t1.RSBusy", 48'(RSBusy), 48'h0);
    end
    chk("t1.Mul", {MulHi, MulLo}, 48'h0);
    chk("t1.Conflict", 48'(Conflict), 48'h0);

    // 2. write r5, write r0 (ignored)
    drive(1, 0, 0, 1, 4'd5, 24'hABCDEF, 0, 0, 0, 0);
    cyc("t2a");
    drive(1, 4'd5, 4'd0, 1, 4'd0, 24'h123456, 0, 0, 0, 0);
    cyc("t2b");
    drive(1, 4'd5, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t2.r5", 48'(ReadRS), 48'hABCDEF);
    chk("t2.r0", 48'(ReadRT), 48'h0);

    // 3. reserve r7, then write it back
    drive(1, 4'd7, 4'd7, 0, 0, 0, 1, 4'd7, 0, 0);
    cyc("t3a");
    drive(1, 4'd7, 4'd7, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t3.busy7", 48'(RSBusy), 48'h1);
    drive(1, 4'd7, 4'd7, 1, 4'd7, 24'h000011, 0, 0, 0, 0);
    cyc("t3b");
    drive(1, 4'd7, 4'd7, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t3.clr7", 48'(RSBusy), 48'h0);
    chk("t3.r7", 48'(ReadRS), 48'h000011);

    // 4. reserve+write r3 in one cycle, then reserve r3 again
    drive(1, 4'd3, 4'd3, 1, 4'd3, 24'h0BEEF3, 1, 4'd3, 0, 0);
    cyc("t4a");
    drive(1, 4'd3, 4'd3, 0, 0, 0, 1, 4'd3, 0, 0);
    #1;
    chk("t4.busy3", 48'(RSBusy), 48'h1);
    chk("t4.r3", 48'(ReadRS), 48'h0BEEF3);
    chk("t4.noconf", 48'(Conflict), 48'h0);
    cyc("t4b");
    drive(1, 4'd3, 4'd3, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t4.conf", 48'(Conflict), 48'h1);
    chk("t4.still", 48'(RSBusy), 48'h1);
    cyc("t4c");
    chk("t4.pulse", 48'(Conflict), 48'h0);

    // 5. MULREG load with concurrent write to r1
    drive(1, 4'd1, 4'd1, 1, 4'd1, 24'h00C0DE, 0, 0, 1, 48'h000002_FFFFFF);
    cyc("t5a");
    drive(1, 4'd1, 4'd1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t5.hi", 48'(MulHi), 48'h000002);
    chk("t5.lo", 48'(MulLo), 48'hFFFFFF);
    chk("t5.r1", 48'(ReadRS), 48'h00C0DE);

    // 6. same-cycle read of a register being written
    drive(1, 0, 0, 1, 4'd9, 24'h111111, 0, 0, 0, 0);
    cyc("t6a");
    drive(1, 4'd9, 4'd9, 1, 4'd9, 24'h55AA55, 0, 0, 0, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t6.fwd", 48'(ReadRS), 48'h55AA55);
`else
    chk("t6.old", 48'(ReadRS), 48'h111111);
`endif
    cyc("t6b");

    // reset while r2 is busy
    drive(1, 4'd2, 4'd2, 0, 0, 0, 1, 4'd2, 0, 0);
    cyc("t6c");
    drive(0, 4'd2, 4'd2, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t6.busy2", 48'(RSBusy), 48'h1);
    cyc("t6d");
    drive(1, 4'd2, 4'd9, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t6.rstbusy", 48'(RSBusy), 48'h0);
    chk("t6.rstr9", 48'(ReadRT), 48'h0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [3:0] rd;
      rd = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 59) != 0),
            ($urandom_range(0, 3) == 0) ? rd : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? rd : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1), rd, 24'($urandom),
            ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0), {16'($urandom), 32'($urandom)});
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_register_file_sb
